// File: rtl/cbox_pkg.sv
// Shared sizing helpers for the multi-context connection box.
// Each output field packs its select in the low bits with the enable bit right above it.
package cbox_pkg;

  localparam int SEL_LSB = 0;

  function automatic int field_w(input int log_inputs);
    return log_inputs + 1;
  endfunction

  function automatic int chain_w(input int outputs, input int log_inputs);
    return outputs * field_w(log_inputs);
  endfunction

  function automatic int en_bit(input int log_inputs);
    return SEL_LSB + log_inputs;
  endfunction

  function automatic int ctx_w(input int contexts);
    return (contexts > 1) ? $clog2(contexts) : 1;
  endfunction

endpackage

// File: rtl/cbox_out_mux.sv
// One routed output: INPUTS:1 select gated by its enable.
module cbox_out_mux #(
  parameter int INPUTS     = 16,
  parameter int LOG_INPUTS = $clog2(INPUTS)
) (
  input  logic [INPUTS-1:0]     data_in,
  input  logic [LOG_INPUTS-1:0] sel,
  input  logic                  en,
  output logic                  dout
);

  // A select at or beyond INPUTS matches no index, so the output stays 0.
  always_comb begin
    dout = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (sel == LOG_INPUTS'(i)) dout = en & data_in[i];
    end
  end

endmodule

// File: rtl/conn_box_multictx.sv
// Connection box with several configuration planes loaded from one serial shadow chain.
// Commit copies the shadow into a plane; a switch selects the live plane in one cycle.
module conn_box_multictx
  import cbox_pkg::*;
#(
  parameter int INPUTS     = 16,
  parameter int LOG_INPUTS = $clog2(INPUTS),
  parameter int OUTPUTS    = 16,
  parameter int CONTEXTS   = 2,
  parameter int CTX_W      = ctx_w(CONTEXTS)
) (
  input  logic                config_clk,
  input  logic                sys_reset,
  input  logic                config_in,
  input  logic                config_en,
  output logic                config_out,
  input  logic                config_commit,
  input  logic [CTX_W-1:0]    commit_ctx,
  input  logic                ctx_switch,
  input  logic [CTX_W-1:0]    ctx_sel,
  output logic [CTX_W-1:0]    active_ctx,
  output logic [CONTEXTS-1:0] ctx_valid,
  input  logic [INPUTS-1:0]   data_in,
  output logic [OUTPUTS-1:0]  data_out
);

  localparam int FW     = field_w(LOG_INPUTS);
  localparam int W      = chain_w(OUTPUTS, LOG_INPUTS);
  localparam int EN_BIT = en_bit(LOG_INPUTS);

  logic [W-1:0]        shadow_q, shadow_d;
  logic [W-1:0]        plane_q [CONTEXTS];
  logic [W-1:0]        plane_d [CONTEXTS];
  logic [CONTEXTS-1:0] ctx_valid_q, ctx_valid_d;
  logic [CTX_W-1:0]    active_ctx_q, active_ctx_d;
  logic [W-1:0]        live_plane;
  logic                live_valid;

  // Commit reads shadow_q, i.e. the value from before any same-cycle shift.
  always_comb begin
    shadow_d     = shadow_q;
    ctx_valid_d  = ctx_valid_q;
    active_ctx_d = active_ctx_q;
    for (int c = 0; c < CONTEXTS; c++) plane_d[c] = plane_q[c];
    if (config_en) shadow_d = {shadow_q[W-2:0], config_in};
    for (int c = 0; c < CONTEXTS; c++) begin
      if (config_commit && (commit_ctx == CTX_W'(c))) begin
        plane_d[c]     = shadow_q;
        ctx_valid_d[c] = 1'b1;
      end
      if (ctx_switch && (ctx_sel == CTX_W'(c))) active_ctx_d = ctx_sel;
    end
  end

  always_ff @(posedge config_clk) begin
    if (sys_reset) begin
      shadow_q     <= '0;
      ctx_valid_q  <= '0;
      active_ctx_q <= '0;
      for (int c = 0; c < CONTEXTS; c++) plane_q[c] <= '0;
    end else begin
      shadow_q     <= shadow_d;
      ctx_valid_q  <= ctx_valid_d;
      active_ctx_q <= active_ctx_d;
      for (int c = 0; c < CONTEXTS; c++) plane_q[c] <= plane_d[c];
    end
  end

  always_comb begin
    live_plane = '0;
    live_valid = 1'b0;
    for (int c = 0; c < CONTEXTS; c++) begin
      if (active_ctx_q == CTX_W'(c)) begin
        live_plane = plane_q[c];
        live_valid = ctx_valid_q[c];
      end
    end
  end

  for (genvar k = 0; k < OUTPUTS; k++) begin : g_out
    cbox_out_mux #(
      .INPUTS    (INPUTS),
      .LOG_INPUTS(LOG_INPUTS)
    ) u_mux (
      .data_in(data_in),
      .sel    (live_plane[k*FW+SEL_LSB +: LOG_INPUTS]),
      .en     (live_plane[k*FW+EN_BIT] & live_valid),
      .dout   (data_out[k])
    );
  end

  assign config_out = shadow_q[W-1];
  assign active_ctx = active_ctx_q;
  assign ctx_valid  = ctx_valid_q;

endmodule

// File: tb/tb_conn_box_multictx.sv
// Bench for conn_box_multictx: 2-context box with a reference model, plus a 3-context box for range checks.
module tb_conn_box_multictx;

  localparam int S  = 4;
  localparam int FW = 5;
  localparam int W  = 20;

  logic        config_clk = 1'b0;
  logic        sys_reset, config_in, config_en, config_out;
  logic        config_commit, commit_ctx, ctx_switch, ctx_sel, active_ctx;
  logic [1:0]  ctx_valid;
  logic [15:0] data_in;
  logic [3:0]  data_out;

  logic        commit3, switch3, cout3;
  logic [1:0]  cctx3, sel3, active3;
  logic [2:0]  valid3;
  logic [3:0]  dout3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 config_clk = ~config_clk;

  conn_box_multictx #(.INPUTS(16), .OUTPUTS(4), .CONTEXTS(2)) dut (
    .config_clk(config_clk), .sys_reset(sys_reset), .config_in(config_in),
    .config_en(config_en), .config_out(config_out), .config_commit(config_commit),
    .commit_ctx(commit_ctx), .ctx_switch(ctx_switch), .ctx_sel(ctx_sel),
    .active_ctx(active_ctx), .ctx_valid(ctx_valid), .data_in(data_in), .data_out(data_out)
  );

  conn_box_multictx #(.INPUTS(16), .OUTPUTS(4), .CONTEXTS(3)) dut3 (
    .config_clk(config_clk), .sys_reset(sys_reset), .config_in(config_in),
    .config_en(config_en), .config_out(cout3), .config_commit(commit3),
    .commit_ctx(cctx3), .ctx_switch(switch3), .ctx_sel(sel3),
    .active_ctx(active3), .ctx_valid(valid3), .data_in(data_in), .data_out(dout3)
  );

  // Reference model: chain as a FIFO of bits (front = oldest = bit W-1), planes as decoded fields.
  bit q[$];
  int msel[2][4];
  bit men[2][4];
  bit mvalid[2];
  int mactive;

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < W; i++) q.push_back(1'b0);
    for (int c = 0; c < 2; c++) begin
      mvalid[c] = 1'b0;
      for (int k = 0; k < 4; k++) begin msel[c][k] = 0; men[c][k] = 1'b0; end
    end
    mactive = 0;
  endfunction

  function automatic void model_edge();
    int c, s;
    if (sys_reset) begin
      model_reset();
      return;
    end
    if (config_commit) begin
      c = int'(commit_ctx);
      for (int k = 0; k < 4; k++) begin
        s = 0;
        for (int b = 0; b < S; b++) if (q[W-1-(k*FW+b)]) s += (1 << b);
        msel[c][k] = s;
        men[c][k]  = q[W-1-(k*FW+S)];
      end
      mvalid[c] = 1'b1;
    end
    if (ctx_switch) mactive = int'(ctx_sel);
    if (config_en) begin
      q.push_back(config_in);
      void'(q.pop_front());
    end
  endfunction

  function automatic logic [3:0] m_dout(input logic [15:0] din);
    logic [3:0] r;
    r = 4'b0;
    if (mvalid[mactive])
      for (int k = 0; k < 4; k++) r[k] = men[mactive][k] & din[msel[mactive][k]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/data_out"},   32'(data_out),   32'(m_dout(data_in)));
    chk({tag, "/config_out"}, 32'(config_out), 32'(q[0]));
    chk({tag, "/ctx_valid"},  32'(ctx_valid),  32'({mvalid[1], mvalid[0]}));
    chk({tag, "/active_ctx"}, 32'(active_ctx), 32'(mactive));
  endtask

  task automatic step();
    model_edge();
    @(posedge config_clk);
    #1;
  endtask

  // Shifts a full plane image; the first bit sent is bit W-1 (output 3 enable).
  task automatic load_shadow(input logic [15:0] sels, input logic [3:0] ens);
    int k, b;
    config_en = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      k = i / FW;
      b = i % FW;
      config_in = (b == S) ? ens[k] : sels[k*4+b];
      step();
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  typedef struct {
    logic [15:0] din;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'h8088, 4'b1011};
    vecs[1] = '{16'h0000, 4'b0000};
    vecs[2] = '{16'h0008, 4'b0001};
    vecs[3] = '{16'h8000, 4'b0010};
    vecs[4] = '{16'h0080, 4'b1000};
    vecs[5] = '{16'hFFFF, 4'b1011};
    vecs[6] = '{16'h7F77, 4'b0000};

    sys_reset = 1'b1; config_in = 1'b0; config_en = 1'b0;
    config_commit = 1'b0; commit_ctx = 1'b0; ctx_switch = 1'b0; ctx_sel = 1'b0;
    commit3 = 1'b0; cctx3 = 2'd0; switch3 = 1'b0; sel3 = 2'd0;
    data_in = 16'hFFFF;
    model_reset();
    step(); step();
    sys_reset = 1'b0;
    #1;
    chk("rst/data_out", 32'(data_out), 0);
    chk("rst/ctx_valid", 32'(ctx_valid), 0);
    chk("rst/active_ctx", 32'(active_ctx), 0);
    chk("rst/config_out", 32'(config_out), 0);
    chk("rst/dout3", 32'(dout3), 0);
    chk("rst/cout3", 32'(cout3), 0);

    // Chain pass-through
    config_en = 1'b1; config_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("chain1/config_out", 32'(config_out), 32'(i >= 20));
    end
    config_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("chain_hold/config_out", 32'(config_out), 1);
    end
    config_en = 1'b1; config_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("chain0/config_out", 32'(config_out), 32'(i < 20));
    end
    config_en = 1'b0;
    check_all("chain_end");

    // ctx0: out3 sel7 en, out2 disabled, out1 sel15 en, out0 sel3 en
    load_shadow(16'h70F3, 4'b1011);
    config_commit = 1'b1; commit_ctx = 1'b0;
    step();
    config_commit = 1'b0;
    chk("commit0/ctx_valid", 32'(ctx_valid), 32'h1);
    for (int i = 0; i < 7; i++) begin
      data_in = vecs[i].din;
      #1;
      chk("vec/data_out", 32'(data_out), 32'(vecs[i].exp));
      chk("vec/model", 32'(data_out), 32'(m_dout(data_in)));
    end

    // ctx1: all sel 0, all enabled; live routing unchanged until the switch
    load_shadow(16'h0000, 4'b1111);
    config_commit = 1'b1; commit_ctx = 1'b1;
    step();
    config_commit = 1'b0;
    data_in = 16'hFFFF;
    #1;
    chk("commit1/data_out_unchanged", 32'(data_out), 32'hB);
    chk("commit1/ctx_valid", 32'(ctx_valid), 32'h3);
    ctx_switch = 1'b1; ctx_sel = 1'b1;
    step();
    ctx_switch = 1'b0;
    data_in = 16'h0001;
    #1;
    chk("switch1/data_out", 32'(data_out), 32'hF);
    chk("switch1/active_ctx", 32'(active_ctx), 1);

    // Simultaneous commit to ctx0 and switch to ctx0; dut3 commits the same shadow to its ctx0
    load_shadow(16'h1234, 4'b1111);
    config_commit = 1'b1; commit_ctx = 1'b0; ctx_switch = 1'b1; ctx_sel = 1'b0;
    commit3 = 1'b1; cctx3 = 2'd0;
    step();
    config_commit = 1'b0; ctx_switch = 1'b0; commit3 = 1'b0;
    data_in = 16'h0010;
    #1;
    chk("simul/data_out", 32'(data_out), 32'h1);
    chk("simul/active_ctx", 32'(active_ctx), 0);
    chk("simul/dout3", 32'(dout3), 32'h1);
    data_in = 16'h0002;
    #1;
    chk("simul/data_out_b", 32'(data_out), 32'h8);
    check_all("simul");

    // Commit into the live plane concurrent with a shift captures the pre-shift shadow
    load_shadow(16'h5555, 4'b1111);
    config_en = 1'b1; config_in = 1'b1; config_commit = 1'b1; commit_ctx = 1'b0;
    step();
    config_en = 1'b0; config_in = 1'b0; config_commit = 1'b0;
    data_in = 16'h0020;
    #1;
    chk("shift_commit/data_out", 32'(data_out), 32'hF);
    check_all("shift_commit");

    // 3-context box: invalid plane, out-of-range switch and commit
    switch3 = 1'b1; sel3 = 2'd1;
    data_in = 16'hFFFF;
    step();
    switch3 = 1'b0;
    chk("ctx3/invalid_plane_dout", 32'(dout3), 0);
    chk("ctx3/active1", 32'(active3), 1);
    switch3 = 1'b1; sel3 = 2'd3;
    step();
    switch3 = 1'b0;
    chk("ctx3/oor_switch_ignored", 32'(active3), 1);
    commit3 = 1'b1; cctx3 = 2'd3;
    step();
    commit3 = 1'b0;
    chk("ctx3/oor_commit_ignored", 32'(valid3), 32'h1);
    commit3 = 1'b1; cctx3 = 2'd2;
    step();
    commit3 = 1'b0;
    chk("ctx3/commit2", 32'(valid3), 32'h5);
    switch3 = 1'b1; sel3 = 2'd0;
    data_in = 16'h0010;
    step();
    switch3 = 1'b0;
    chk("ctx3/back_to_0", 32'(dout3), 32'h1);

    // Reset in the middle of a shift
    config_en = 1'b1; config_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    sys_reset = 1'b1;
    step();
    sys_reset = 1'b0; config_en = 1'b0;
    data_in = 16'hFFFF;
    #1;
    chk("midrst/data_out", 32'(data_out), 0);
    chk("midrst/ctx_valid", 32'(ctx_valid), 0);
    chk("midrst/active_ctx", 32'(active_ctx), 0);
    chk("midrst/config_out", 32'(config_out), 0);
    chk("midrst/dout3", 32'(dout3), 0);
    chk("midrst/valid3", 32'(valid3), 0);
    chk("midrst/active3", 32'(active3), 0);
    config_en = 1'b1; config_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("midrst_reload/config_out", 32'(config_out), 32'(i >= 20));
    end
    config_en = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      sys_reset     = ($urandom_range(0, 59) == 0);
      config_en     = ($urandom_range(0, 3) != 0);
      config_in     = 1'($urandom);
      config_commit = ($urandom_range(0, 5) == 0);
      commit_ctx    = 1'($urandom);
      ctx_switch    = ($urandom_range(0, 5) == 0);
      ctx_sel       = 1'($urandom);
      data_in       = 16'($urandom);
      step();
      check_all("rand");
      data_in = 16'($urandom);
      #1;
      chk("rand/comb_data_out", 32'(data_out), 32'(m_dout(data_in)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
